// File: rtl/gemmm2s_pkg.sv
// Shared types and limits for the gemmm2s DMA/TLAST path.
// The defaults are also used for the TLAST calculator's outstanding-packet limit.
package gemmm2s_pkg;

    localparam int DEFAULT_MAX_PENDING  = 4;
    localparam int DEFAULT_STARVE_LIMIT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FIRE = 2'd2
    } dma_sched_state_t;

endpackage

// File: rtl/dma_complete_sched_if.sv
// Valid/ready address-beat channel between the AW tap, the scheduler and the TLAST calculator.
interface dma_complete_sched_if #(
    parameter int ADDR_WIDTH = 12
);

    logic [ADDR_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/dma_complete_sched.sv
// Queues PS DMA-complete pulses and re-issues each one in a cycle where no address beat
// can be accepted, so the calculator never sees a completion and a beat together.
module dma_complete_sched
    import gemmm2s_pkg::*;
#(
    parameter int  ADDR_WIDTH   = 12,
    parameter int  MAX_PENDING  = DEFAULT_MAX_PENDING,
    parameter int  STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    localparam int PEND_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_irq_done,
    dma_complete_sched_if.slave     s_addr,
    dma_complete_sched_if.master    m_addr,
    output logic                    o_dma_complete,
    output logic [PEND_W-1:0]       o_pending,
    output logic                    o_overflow
);

    localparam int                  STARVE_W   = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT - 1);
    localparam logic [PEND_W-1:0]   PEND_MAX   = PEND_W'(MAX_PENDING);

    dma_sched_state_t      state_q, state_d;
    logic [PEND_W-1:0]     pending_q, pending_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  overflow_q, overflow_d;
    logic                  dma_complete_q, dma_complete_d;
    logic                  fire;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] beat_data;

    // A full queue still takes a new pulse in the cycle it releases one.
    always_comb begin
        fire           = (state_q == WAIT) && (!s_addr.valid || starve_q == STARVE_MAX);
        accept         = i_irq_done && !(pending_q == PEND_MAX && !fire);
        pending_d      = pending_q + PEND_W'(accept) - PEND_W'(fire);
        overflow_d     = overflow_q || (i_irq_done && !accept);
        state_d        = state_q;
        starve_d       = starve_q;

        case (state_q)
            IDLE: begin
                starve_d = '0;
                if (pending_q != '0 || i_irq_done) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (fire) begin
                    state_d  = FIRE;
                    starve_d = '0;
                end else if (starve_q != STARVE_MAX) begin
                    starve_d = starve_q + 1'b1;
                end
            end
            FIRE: begin
                starve_d = '0;
                state_d  = (pending_d != '0) ? WAIT : IDLE;
            end
            default: begin
                state_d  = IDLE;
                starve_d = '0;
            end
        endcase

        dma_complete_d = (state_d == FIRE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            pending_q      <= '0;
            starve_q       <= '0;
            overflow_q     <= 1'b0;
            dma_complete_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            starve_q       <= starve_d;
            overflow_q     <= overflow_d;
            dma_complete_q <= dma_complete_d;
        end
    end

    // The beat channel is blocked for exactly the completion cycle and while in reset.
    assign beat_data      = s_addr.data;
    assign m_addr.data    = beat_data;
    assign m_addr.valid   = reset_n && s_addr.valid && !dma_complete_q;
    assign s_addr.ready   = reset_n && m_addr.ready && !dma_complete_q;

    assign o_dma_complete = dma_complete_q;
    assign o_pending      = pending_q;
    assign o_overflow     = overflow_q;

endmodule

// File: tb/tb_dma_complete_sched.sv
// Self-checking bench for dma_complete_sched: vector table, a pulse-cycle scoreboard,
// and hand-built sequences for starvation, overflow, back-to-back and reset cases.
module tb_dma_complete_sched;

    localparam int AW = 12;
    localparam int MP = 4;
    localparam int SL = 16;
    localparam int PW = $clog2(MP + 1);

    typedef struct {
        logic          irq;
        logic          s_valid;
        logic          m_ready;
        logic [AW-1:0] addr;
        logic          exp_dma;
        logic [PW-1:0] exp_pend;
        logic          exp_s_ready;
        logic          exp_m_valid;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          irq = 1'b0;
    logic          dma_complete;
    logic [PW-1:0] pending;
    logic          overflow;

    dma_complete_sched_if #(.ADDR_WIDTH(AW)) s_if ();
    dma_complete_sched_if #(.ADDR_WIDTH(AW)) m_if ();

    dma_complete_sched #(
        .ADDR_WIDTH   (AW),
        .MAX_PENDING  (MP),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_irq_done     (irq),
        .s_addr         (s_if),
        .m_addr         (m_if),
        .o_dma_complete (dma_complete),
        .o_pending      (pending),
        .o_overflow     (overflow)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_pulse = -100;
    int   exp_q[$];
    vec_t vecs[7];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply_stimulus(input logic irq_v, input logic s_valid_v, input logic m_ready_v,
                                  input logic [AW-1:0] addr_v);
        irq         = irq_v;
        s_if.valid  = s_valid_v;
        m_if.ready  = m_ready_v;
        s_if.data   = addr_v;
    endtask

    // Negedge sample: scoreboard pops on each pulse, channel gating checked every cycle.
    task automatic sample();
        @(negedge clk);
        while (exp_q.size() > 0 && exp_q[0] < cyc) begin
            check_output("missed_pulse", cyc, exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (dma_complete === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL unexpected_pulse: got pulse at cycle %0d, expected none", cyc);
            end else begin
                check_output("pulse_cycle", cyc, exp_q.pop_front());
            end
            check_output("pulse_spacing_ge2", 32'(cyc - last_pulse >= 2), 1);
            last_pulse = cyc;
        end
        check_output("m_addr_valid", m_if.valid, reset_n & s_if.valid & ~dma_complete);
        check_output("s_addr_ready", s_if.ready, reset_n & m_if.ready & ~dma_complete);
        check_output("m_addr_data", m_if.data, s_if.data);
    endtask

    task automatic advance();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        int t0;
        int t1;
        int pulses;
        int peak;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 3'd1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 12'h000, 1'b1, 3'd0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 12'h5A5, 1'b0, 3'd0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 12'h3C3, 1'b0, 3'd0, 1'b0, 1'b1};

        apply_stimulus(1'b0, 1'b1, 1'b1, 12'hABC);
        repeat (2) @(posedge clk);
        #2;
        check_output("rst_dma_complete", dma_complete, 0);
        check_output("rst_pending", pending, 0);
        check_output("rst_overflow", overflow, 0);
        check_output("rst_s_ready", s_if.ready, 0);
        check_output("rst_m_valid", m_if.valid, 0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 12'h000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;

        $display("[TB] idle-bus vector table, irq at cycle 10");
        repeat (9) begin
            sample();
            advance();
        end
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i].irq, vecs[i].s_valid, vecs[i].m_ready, vecs[i].addr);
            if (vecs[i].irq) exp_q.push_back(cyc + 2);
            sample();
            check_output("vec_dma_complete", dma_complete, vecs[i].exp_dma);
            check_output("vec_pending", pending, vecs[i].exp_pend);
            check_output("vec_s_ready", s_if.ready, vecs[i].exp_s_ready);
            check_output("vec_m_valid", m_if.valid, vecs[i].exp_m_valid);
            advance();
        end
        irq = 1'b0;

        $display("[TB] saturated bus, forced stall after starvation limit");
        t0 = cyc;
        exp_q.push_back(t0 + SL + 1);
        while (cyc <= t0 + SL + 3) begin
            apply_stimulus(cyc == t0, 1'b1, 1'b1, 12'h123);
            sample();
            if (cyc > t0 && cyc <= t0 + SL) check_output("sat_pending", pending, 1);
            if (cyc == t0 + SL + 1) begin
                check_output("stall_dma_complete", dma_complete, 1);
                check_output("stall_s_ready", s_if.ready, 0);
                check_output("stall_m_valid", m_if.valid, 0);
                check_output("stall_pending", pending, 0);
            end
            if (cyc == t0 + SL + 2) begin
                check_output("held_beat_s_ready", s_if.ready, 1);
                check_output("held_beat_m_valid", m_if.valid, 1);
                check_output("held_beat_data", m_if.data, 12'h123);
            end
            advance();
        end

        $display("[TB] bus goes idle five cycles after irq");
        t0 = cyc;
        exp_q.push_back(t0 + 6);
        while (cyc <= t0 + 8) begin
            apply_stimulus(cyc == t0, cyc != t0 + 5, 1'b1, 12'h222);
            sample();
            if (cyc == t0 + 5) check_output("idle_fire_pending", pending, 1);
            if (cyc == t0 + 6) check_output("idle_fire_pending_after", pending, 0);
            advance();
        end
        t1 = cyc;
        exp_q.push_back(t1 + SL + 1);
        while (cyc <= t1 + SL + 3) begin
            apply_stimulus(cyc == t1, 1'b1, 1'b1, 12'h333);
            sample();
            advance();
        end

        $display("[TB] six back-to-back irqs into a four-deep queue");
        t0 = cyc;
        pulses = 0;
        peak = 0;
        for (int k = 1; k <= MP; k++) exp_q.push_back(t0 + k * (SL + 1));
        while (cyc <= t0 + 4 * (SL + 1) + 4) begin
            apply_stimulus(cyc < t0 + 6, 1'b1, 1'b1, 12'h444);
            sample();
            if (dma_complete === 1'b1) pulses++;
            if (int'(pending) > peak) peak = int'(pending);
            if (cyc == t0 + 4) begin
                check_output("full_pending", pending, MP);
                check_output("full_overflow_before", overflow, 0);
            end
            if (cyc == t0 + 5) check_output("full_overflow_set", overflow, 1);
            advance();
        end
        check_output("burst_peak_pending", peak, MP);
        check_output("burst_pulse_count", pulses, MP);
        check_output("burst_overflow_sticky", overflow, 1);
        check_output("burst_pending_drained", pending, 0);

        $display("[TB] asynchronous reset mid-wait with three queued");
        t0 = cyc;
        while (cyc <= t0 + 4) begin
            apply_stimulus(cyc < t0 + 3, 1'b1, 1'b1, 12'h555);
            sample();
            if (cyc == t0 + 4) check_output("pre_reset_pending", pending, 3);
            advance();
        end
        irq = 1'b0;
        reset_n = 1'b0;
        #2;
        check_output("async_rst_pending", pending, 0);
        check_output("async_rst_dma_complete", dma_complete, 0);
        check_output("async_rst_overflow", overflow, 0);
        check_output("async_rst_s_ready", s_if.ready, 0);
        check_output("async_rst_m_valid", m_if.valid, 0);
        advance();
        advance();
        reset_n = 1'b1;
        repeat (40) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, 12'h000);
            sample();
            check_output("post_reset_pending", pending, 0);
            advance();
        end

        $display("[TB] irq coincident with fire at pending=1");
        t0 = cyc;
        exp_q.push_back(t0 + 2);
        exp_q.push_back(t0 + 4);
        while (cyc <= t0 + 7) begin
            apply_stimulus(cyc == t0 || cyc == t0 + 1, 1'b0, 1'b1, 12'h000);
            sample();
            if (cyc == t0 + 2) check_output("coincide_pending_fire1", pending, 1);
            if (cyc == t0 + 3) check_output("coincide_pending_wait", pending, 1);
            if (cyc == t0 + 4) check_output("coincide_pending_fire2", pending, 0);
            advance();
        end
        check_output("coincide_no_overflow", overflow, 0);

        check_output("scoreboard_leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
